// File: rtl/mp_reg_file.sv
// Multi-port register file: byte-strobed writes with highest-port-wins merging,
// registered reads with selectable read-during-write behaviour, and a sequential clear sweep.
module mp_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_WR*DATA_WIDTH/8-1:0] wr_strb,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  input  logic                           clr_req,
  output logic                           busy,
  output logic                           wr_err
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [ADDR_WIDTH-1:0]   clr_ptr_nxt;
  logic [DATA_WIDTH-1:0]   mem     [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_nxt [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word_c [NUM_RD];
  logic                    wr_oor_c;

  // Controller state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state: one entry cleared per cycle, sweep ends after entry DEPTH-1
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_WIDTH'(1);
        if (clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Post-write image of storage; ports applied in ascending order so the highest port wins per byte
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_nxt[i] = mem[i];
    wr_oor_c = 1'b0;
    if (state == CLEAR) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (clr_ptr == ADDR_WIDTH'(i)) mem_nxt[i] = '0;
      end
    end else if (!clr_req) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k]) begin
          if (32'(wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) >= DEPTH) begin
            wr_oor_c = 1'b1;
          end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                  if (wr_strb[k*NB + b])
                    mem_nxt[i][8*b +: 8] = wr_data[k*DATA_WIDTH + 8*b +: 8];
                end
              end
            end
          end
        end
      end
    end
  end

  // Storage is never reset; the clear sweep zeroes it
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
    end
  end

  // Read word select; out-of-range addresses match no entry and return zero
  always_comb begin
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      rd_word_c[j] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))
          rd_word_c[j] = (BYPASS != 0) ? mem_nxt[i] : mem[i];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= '0;
      wr_err   <= 1'b0;
      busy     <= 1'b1;
    end else begin
      busy     <= (state_nxt == CLEAR);
      wr_err   <= wr_oor_c;
      rd_valid <= '0;
      if (state == IDLE) begin
        for (int unsigned j = 0; j < NUM_RD; j++) begin
          if (rd_en[j]) begin
            rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= rd_word_c[j];
            rd_valid[j]                         <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file: two instances (write-first DEPTH 16, read-first DEPTH 12) share
// stimulus and are compared every cycle against a spec-level reference model.
module tb_mp_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        clr_req;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b, wr_err_a, wr_err_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mp_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .NUM_WR(2), .NUM_RD(2), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .clr_req(clr_req), .busy(busy_a), .wr_err(wr_err_a));

  mp_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .NUM_WR(2), .NUM_RD(2), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .clr_req(clr_req), .busy(busy_b), .wr_err(wr_err_b));

  // Reference model state, index 0 = u_a, 1 = u_b
  logic [31:0] mm     [2][16];
  logic [31:0] exp_rd [2][2];
  logic [1:0]  exp_rv [2];
  logic        exp_busy [2];
  logic        exp_err  [2];
  int          clr_left [2];
  int          dep [2] = '{16, 12};
  int          byp [2] = '{1, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] post [16];
      if (reset) begin
        exp_busy[d] = 1'b1;
        exp_err[d]  = 1'b0;
        exp_rv[d]   = 2'b00;
        exp_rd[d][0] = '0;
        exp_rd[d][1] = '0;
        clr_left[d] = dep[d];
        for (int a = 0; a < 16; a++) mm[d][a] = '0;
      end else if (clr_left[d] > 0) begin
        clr_left[d]--;
        exp_busy[d] = (clr_left[d] > 0);
        exp_err[d]  = 1'b0;
        exp_rv[d]   = 2'b00;
      end else begin
        for (int a = 0; a < 16; a++) post[a] = mm[d][a];
        exp_err[d] = 1'b0;
        if (!clr_req) begin
          for (int k = 0; k < 2; k++) begin
            if (wr_en[k]) begin
              int wa;
              wa = int'(wr_addr[k*4 +: 4]);
              if (wa >= dep[d]) exp_err[d] = 1'b1;
              else
                for (int b = 0; b < 4; b++)
                  if (wr_strb[k*4 + b]) post[wa][8*b +: 8] = wr_data[k*32 + 8*b +: 8];
            end
          end
        end
        for (int j = 0; j < 2; j++) begin
          if (rd_en[j]) begin
            int ra;
            ra = int'(rd_addr[j*4 +: 4]);
            if (ra >= dep[d])     exp_rd[d][j] = '0;
            else if (byp[d] != 0) exp_rd[d][j] = post[ra];
            else                  exp_rd[d][j] = mm[d][ra];
            exp_rv[d][j] = 1'b1;
          end else begin
            exp_rv[d][j] = 1'b0;
          end
        end
        for (int a = 0; a < 16; a++) mm[d][a] = post[a];
        if (clr_req) begin
          clr_left[d] = dep[d];
          exp_busy[d] = 1'b1;
          for (int a = 0; a < 16; a++) mm[d][a] = '0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("busy_a",     64'(busy_a),     64'(exp_busy[0]));
    check("wr_err_a",   64'(wr_err_a),   64'(exp_err[0]));
    check("rd_valid_a", 64'(rd_valid_a), 64'(exp_rv[0]));
    check("rd_data_a",  rd_data_a,       {exp_rd[0][1], exp_rd[0][0]});
    check("busy_b",     64'(busy_b),     64'(exp_busy[1]));
    check("wr_err_b",   64'(wr_err_b),   64'(exp_err[1]));
    check("rd_valid_b", 64'(rd_valid_b), 64'(exp_rv[1]));
    check("rd_data_b",  rd_data_b,       {exp_rd[1][1], exp_rd[1][0]});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    reset = 1'b0; clr_req = 1'b0;
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  // Counts steps until each instance drops busy; 0 means it never did within the bound
  task automatic wait_clear(input int exp_a, input int exp_b);
    int na = 0;
    int nb = 0;
    for (int n = 1; n <= 40 && (na == 0 || nb == 0); n++) begin
      step();
      if (na == 0 && !busy_a) na = n;
      if (nb == 0 && !busy_b) nb = n;
    end
    check("clr_len_a", 64'(na), 64'(exp_a));
    check("clr_len_b", 64'(nb), 64'(exp_b));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_busy", 64'(busy_a), 64'd1);
    reset = 1'b0;
    wait_clear(16, 12);

    // Every address reads zero after the sweep
    for (int a = 0; a < 16; a++) begin
      idle(); rd_en = 2'b11; rd_addr = {4'(a), 4'(a)};
      step();
      check("clr_rd_a", 64'(rd_data_a[31:0]), 64'd0);
      check("clr_rv_a", 64'(rd_valid_a), 64'd3);
    end

    // Byte strobes
    idle(); wr_en = 2'b01; wr_addr = 8'h03; wr_data = {32'h0, 32'hAABBCCDD}; wr_strb = 8'h0F;
    step();
    idle(); wr_en = 2'b01; wr_addr = 8'h03; wr_data = {32'h0, 32'h11223344}; wr_strb = 8'h05;
    step();
    idle(); rd_en = 2'b01; rd_addr = 8'h03;
    step();
    check("strb_a", 64'(rd_data_a[31:0]), 64'hAA22CC44);
    check("strb_b", 64'(rd_data_b[31:0]), 64'hAA22CC44);

    // Same-address conflict, port 1 wins on its strobed bytes
    idle(); wr_en = 2'b11; wr_addr = 8'h55; wr_data = {32'h22222222, 32'h11111111}; wr_strb = 8'h3F;
    step();
    idle(); rd_en = 2'b10; rd_addr = 8'h50;
    step();
    check("conflict", 64'(rd_data_a[63:32]), 64'h11112222);

    // Read-during-write on addr 7
    idle(); wr_en = 2'b01; wr_addr = 8'h07; wr_data = {32'h0, 32'hDEADBEEF}; wr_strb = 8'h0F;
    rd_en = 2'b01; rd_addr = 8'h07;
    step();
    check("rdw_first", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    check("rdw_old",   64'(rd_data_b[31:0]), 64'h0);
    idle(); rd_en = 2'b01; rd_addr = 8'h07;
    step();
    check("rdw_next_b", 64'(rd_data_b[31:0]), 64'hDEADBEEF);

    // Out-of-range writes on the DEPTH=12 instance
    idle(); wr_en = 2'b11; wr_addr = 8'hED; wr_data = {32'h87654321, 32'h12345678}; wr_strb = 8'hFF;
    step();
    check("oor_err_b", 64'(wr_err_b), 64'd1);
    check("oor_err_a", 64'(wr_err_a), 64'd0);
    idle(); rd_en = 2'b11; rd_addr = 8'h3E;
    step();
    check("oor_pulse", 64'(wr_err_b), 64'd0);
    check("oor_rd",    64'(rd_data_b[31:0]), 64'd0);
    check("oor_rv",    64'(rd_valid_b), 64'd3);
    check("oor_keep",  64'(rd_data_b[63:32]), 64'hAA22CC44);

    // clr_req drops a same-cycle write but still services the read
    idle(); clr_req = 1'b1; wr_en = 2'b01; wr_addr = 8'h02; wr_data = 64'h5; wr_strb = 8'h0F;
    rd_en = 2'b01; rd_addr = 8'h03;
    step();
    check("clr_rd", 64'(rd_data_a[31:0]), 64'hAA22CC44);
    idle();
    wait_clear(16, 12);
    idle(); rd_en = 2'b01; rd_addr = 8'h02;
    step();
    check("clr_drop", 64'(rd_data_a[31:0]), 64'd0);

    // Reset mid-sweep restarts the full clear
    idle(); clr_req = 1'b1;
    step();
    idle();
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_clear(16, 12);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      wr_en   = 2'($urandom);
      rd_en   = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        wr_addr[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        rd_addr[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      wr_data = {32'($urandom), 32'($urandom)};
      wr_strb = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
